lsu_unit: RTL

- Load/store unit directly downstream of the ALU.
- Consumes the ALU result as the effective byte address, and rs2 as store data.
- Runs one data-memory transaction per accepted request over a request/acknowledge interface with variable latency.
- Returns sign- or zero-extended load data, or flags misaligned and illegal accesses without touching memory.

---
 rtl/lsu_if.sv | 36 +++
 rtl/lsu_unit.sv | 119 +++++++++++
 2 files changed

// File: rtl/lsu_if.sv
// Core-side request/response and data-memory handshake signals of the load/store unit.
interface lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              is_load;
    logic              is_store;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              resp_valid;
    logic [31:0]       rdata;
    logic              misaligned;
    logic              illegal;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    // master: the core plus the memory it talks to; slave: the LSU itself
    modport master (
        output req_valid, is_load, is_store, funct3, addr, wdata, mem_ack, mem_rdata,
        input  req_ready, busy, resp_valid, rdata, misaligned, illegal,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
    modport slave (
        input  req_valid, is_load, is_store, funct3, addr, wdata, mem_ack, mem_rdata,
        output req_ready, busy, resp_valid, rdata, misaligned, illegal,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_unit.sv
// Load/store unit: one memory transaction per request, lane steering for stores,
// sign/zero extension for loads, misaligned/illegal faults reported without a memory access.
module lsu_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t     state;
    logic [2:0] f3_q;
    logic [1:0] lane_q;
    logic       ld_q;

    logic        accept, ill_c, mis_c;
    logic [3:0]  be_c;
    logic [31:0] wd_c, sh_word, ext_c;

    assign accept = bus.req_valid && (bus.is_load || bus.is_store);

    always_comb begin
        ill_c = (bus.is_load && bus.is_store)
             || (bus.is_load  && (bus.funct3 == 3'd3 || bus.funct3 == 3'd6 || bus.funct3 == 3'd7))
             || (bus.is_store && bus.funct3 > 3'd2);
        mis_c = (bus.funct3[1:0] == 2'b01 && bus.addr[0])
             || (bus.funct3[1:0] == 2'b10 && bus.addr[1:0] != 2'b00);
        be_c  = 4'b1111;
        wd_c  = bus.wdata;
        case (bus.funct3[1:0])
            2'b00: begin
                be_c = 4'b0001 << bus.addr[1:0];
                wd_c = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
                be_c = 4'b0011 << {bus.addr[1], 1'b0};
                wd_c = {2{bus.wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane select happens before extension so the same shifter serves B and H.
    always_comb begin
        sh_word = bus.mem_rdata >> {lane_q, 3'b000};
        ext_c   = bus.mem_rdata;
        case (f3_q)
            3'd0: ext_c = {{24{sh_word[7]}},  sh_word[7:0]};
            3'd1: ext_c = {{16{sh_word[15]}}, sh_word[15:0]};
            3'd4: ext_c = {24'd0, sh_word[7:0]};
            3'd5: ext_c = {16'd0, sh_word[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            f3_q           <= '0;
            lane_q         <= '0;
            ld_q           <= 1'b0;
            bus.req_ready  <= 1'b1;
            bus.busy       <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.rdata      <= '0;
            bus.misaligned <= 1'b0;
            bus.illegal    <= 1'b0;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_be     <= '0;
            bus.mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    f3_q          <= bus.funct3;
                    lane_q        <= bus.addr[1:0];
                    ld_q          <= bus.is_load;
                    bus.req_ready <= 1'b0;
                    bus.busy      <= 1'b1;
                    if (ill_c || mis_c) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.illegal    <= ill_c;
                        bus.misaligned <= mis_c && !ill_c;
                        bus.rdata      <= '0;
                    end else begin
                        state          <= ACCESS;
                        bus.mem_req    <= 1'b1;
                        bus.mem_we     <= bus.is_store;
                        bus.mem_addr   <= {bus.addr[ADDR_W-1:2], 2'b00};
                        bus.mem_be     <= be_c;
                        bus.mem_wdata  <= wd_c;
                    end
                end
                ACCESS: if (bus.mem_ack) begin
                    state          <= RESP;
                    bus.mem_req    <= 1'b0;
                    bus.mem_we     <= 1'b0;
                    bus.mem_be     <= '0;
                    bus.resp_valid <= 1'b1;
                    bus.rdata      <= ld_q ? ext_c : '0;
                end
                RESP: begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.rdata      <= '0;
                    bus.misaligned <= 1'b0;
                    bus.illegal    <= 1'b0;
                    bus.busy       <= 1'b0;
                    bus.req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
